ship_state_update: RTL
======================

// Module: ship_state_update
// PURPOSE
//  Datapath stage driven by the game FSM's shipUpdateEn. Once per update tick it moves the
//  user ship from player buttons and bounces the enemy ship between the X limits. It also
//  issues fire requests toward the grid and tracks user health from grid hit reports.
//  ship_health feeds back to the FSM (0 => game over); user_x/enemy_x feed the draw path.
// PARAMETERS
//  X_MIN          8'd0    leftmost legal ship x
//  X_MAX          8'd152  rightmost legal ship x (160-px screen minus 8-px ship)
//  X_START        8'd80   x of both ships after reset
//  USER_STEP      8'd2    user px moved per tick
//  ENEMY_STEP     8'd1    enemy px moved per tick
//  MAX_HEALTH     4'd8    health after reset
//  INVULN_TICKS   5'd16   ticks of hit immunity after a counted hit
//  FIRE_COOLDOWN  3'd4    ticks between accepted shots
// PORTS
//  clk            in   1  system clock (50 MHz)
//  reset          in   1  synchronous, active-high reset
//  shipUpdateEn   in   1  level from FSM, high for all of S_UPDATE
//  move_left      in   1  player left button, active-high, debounced
//  move_right     in   1  player right button, active-high, debounced
//  fire           in   1  player fire button, active-high
//  hit            in   1  1-cycle pulse from grid: enemy shot reached user ship
//  user_x         out  8  user ship x
//  enemy_x        out  8  enemy ship x
//  ship_health    out  4  user health, 0 = dead
//  fire_pulse     out  1  1-cycle shot request to grid
//  bullet_x       out  8  spawn x for shot, valid while fire_pulse=1
//  invuln         out  1  high while hit immunity counter != 0 (draw flashes ship)
// BEHAVIOUR
//  Reset (sync, wins over everything): user_x=enemy_x=X_START, ship_health=MAX_HEALTH,
//   fire_pulse=0, bullet_x=0, invuln=0, counters=0, enemy dir=RIGHT, upd_d=0.
//  tick = shipUpdateEn & ~upd_d (upd_d = shipUpdateEn delayed 1 clk): one tick per
//   S_UPDATE entry regardless of how long the level is held. All updates are registered:
//   results visible the cycle after the tick.
//  Dead (ship_health==0): no movement, no fire, hits ignored. Outputs hold until reset.
//  User move on tick: left only => x-USER_STEP, clamped to X_MIN (no underflow wrap).
//   Right only => x+USER_STEP, clamped to X_MAX. Both or neither => hold.
//  Enemy FSM states are E_RIGHT and E_LEFT. On tick in E_RIGHT: if enemy_x+ENEMY_STEP>=X_MAX,
//   set enemy_x=X_MAX and go to E_LEFT. Else add ENEMY_STEP. E_LEFT mirrors this with X_MIN.
//   Arriving exactly at a limit flips direction in that same tick.
//  Fire: on tick with fire=1, cooldown==0 and alive: fire_pulse=1 for exactly 1 clk,
//   bullet_x=pre-move user_x+4, cooldown=FIRE_COOLDOWN. Otherwise, if cooldown!=0, it
//   decrements by 1 per tick. The fire button is level-sampled only at ticks.
//  Hit: sampled every clk. If hit=1, alive and invuln counter==0: health-=1 and
//   invuln counter=INVULN_TICKS. Health saturates at 0. Invuln counter decrements once per
//   tick. A hit on the same clk as a tick applies both; the counter loads and does not
//   decrement. A hit while invuln!=0 is dropped.
//  Simultaneous tick and last hit (health 1->0): that tick's movement/fire still applies.
//   The next tick is frozen.
//  Internal x math is 9-bit to detect over/underflow before clamping. Outputs are 8-bit.
// TESTING
//  T1 Reset, then 3 ticks (shipUpdateEn high 5 clks each) with no buttons -> user_x=80,
//     enemy_x=83, health=8; a held level yields exactly 1 step per tick.
//  T2 user_x=1, move_left 1 tick -> user_x=0. user_x=151, move_right -> 152. Both buttons
//     -> unchanged.
//  T3 Run 72 ticks from reset -> enemy reaches 152 at tick 72, direction=LEFT, tick 73 -> 151.
//  T4 fire held 10 ticks, user_x=80 -> fire_pulse on ticks 1,6 (1 clk each), bullet_x=84.
//  T5 hit at clk N, again at N+3, and hit coincident with tick -> health 8->7 only,
//     invuln=1 for 16 ticks, next hit after expiry -> 6.
//  T6 8 spaced hits -> health=0, later ticks freeze x/fire. Reset mid-game -> all outputs
//     at reset values next clk.

Source files
------------

// File: rtl/ship_if.sv
// Signal bundle between the game FSM / input path and the ship state update stage.
// master drives buttons, update enable and grid hit reports; slave is the update stage.
interface ship_if;
    logic       shipUpdateEn;
    logic       move_left;
    logic       move_right;
    logic       fire;
    logic       hit;
    logic [7:0] user_x;
    logic [7:0] enemy_x;
    logic [3:0] ship_health;
    logic       fire_pulse;
    logic [7:0] bullet_x;
    logic       invuln;

    modport master (
        output shipUpdateEn,
        output move_left,
        output move_right,
        output fire,
        output hit,
        input  user_x,
        input  enemy_x,
        input  ship_health,
        input  fire_pulse,
        input  bullet_x,
        input  invuln
    );

    modport slave (
        input  shipUpdateEn,
        input  move_left,
        input  move_right,
        input  fire,
        input  hit,
        output user_x,
        output enemy_x,
        output ship_health,
        output fire_pulse,
        output bullet_x,
        output invuln
    );
endinterface

// File: rtl/ship_state_update.sv
// Ship state update stage: once per S_UPDATE entry moves the user ship from the
// buttons, bounces the enemy between the x limits, issues shots and tracks health.
//
// Enemy direction FSM
//   state   | meaning
//   E_RIGHT | enemy moving toward X_MAX on each tick
//   E_LEFT  | enemy moving toward X_MIN on each tick
module ship_state_update #(
    parameter logic [7:0] X_MIN         = 8'd0,
    parameter logic [7:0] X_MAX         = 8'd152,
    parameter logic [7:0] X_START       = 8'd80,
    parameter logic [7:0] USER_STEP     = 8'd2,
    parameter logic [7:0] ENEMY_STEP    = 8'd1,
    parameter logic [3:0] MAX_HEALTH    = 4'd8,
    parameter logic [4:0] INVULN_TICKS  = 5'd16,
    parameter logic [2:0] FIRE_COOLDOWN = 3'd4
) (
    input  logic  clk,
    input  logic  reset,
    ship_if.slave bus
);

    typedef enum logic {
        E_RIGHT = 1'b0,
        E_LEFT  = 1'b1
    } enemy_state_t;

    // 9-bit copies of the limits so over/underflow is visible before clamping.
    localparam logic [8:0] X_MIN9      = {1'b0, X_MIN};
    localparam logic [8:0] X_MAX9      = {1'b0, X_MAX};
    localparam logic [8:0] USER_STEP9  = {1'b0, USER_STEP};
    localparam logic [8:0] ENEMY_STEP9 = {1'b0, ENEMY_STEP};
    localparam logic [7:0] BULLET_OFS  = 8'd4;

    logic         upd_d;
    logic         tick;
    logic         alive;

    logic [7:0]   user_x_q;
    logic [7:0]   user_x_d;
    logic [8:0]   user_sum9;

    enemy_state_t state_q;
    enemy_state_t state_d;
    logic [7:0]   enemy_x_q;
    logic [7:0]   enemy_x_d;
    logic [8:0]   enemy_sum9;

    logic [3:0]   health_q;
    logic [4:0]   inv_cnt_q;
    logic [2:0]   cooldown_q;
    logic         fire_pulse_q;
    logic [7:0]   bullet_x_q;

    // One tick per rising edge of the update level, however long it is held.
    assign tick  = bus.shipUpdateEn & ~upd_d;
    assign alive = (health_q != 4'd0);

    // Edge detector register for the update enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_d <= 1'b0;
        end else begin
            upd_d <= bus.shipUpdateEn;
        end
    end

    // User ship next position: single button moves one step, clamped at the limits.
    always_comb begin
        user_x_d  = user_x_q;
        user_sum9 = {1'b0, user_x_q} + USER_STEP9;
        if (tick && alive) begin
            if (bus.move_left && !bus.move_right) begin
                if ({1'b0, user_x_q} < (X_MIN9 + USER_STEP9)) begin
                    user_x_d = X_MIN;
                end else begin
                    user_x_d = user_x_q - USER_STEP;
                end
            end else if (bus.move_right && !bus.move_left) begin
                if (user_sum9 > X_MAX9) begin
                    user_x_d = X_MAX;
                end else begin
                    user_x_d = user_sum9[7:0];
                end
            end
        end
    end

    // User ship position register.
    always_ff @(posedge clk) begin
        if (reset) begin
            user_x_q <= X_START;
        end else begin
            user_x_q <= user_x_d;
        end
    end

    // Enemy FSM next state and position: reaching a limit flips direction on the same tick.
    always_comb begin
        state_d    = state_q;
        enemy_x_d  = enemy_x_q;
        enemy_sum9 = {1'b0, enemy_x_q} + ENEMY_STEP9;
        if (tick && alive) begin
            case (state_q)
                E_RIGHT: begin
                    if (enemy_sum9 >= X_MAX9) begin
                        enemy_x_d = X_MAX;
                        state_d   = E_LEFT;
                    end else begin
                        enemy_x_d = enemy_sum9[7:0];
                    end
                end
                E_LEFT: begin
                    if ({1'b0, enemy_x_q} <= (X_MIN9 + ENEMY_STEP9)) begin
                        enemy_x_d = X_MIN;
                        state_d   = E_RIGHT;
                    end else begin
                        enemy_x_d = enemy_x_q - ENEMY_STEP;
                    end
                end
                default: begin
                    state_d = E_RIGHT;
                end
            endcase
        end
    end

    // Enemy FSM state and position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= E_RIGHT;
            enemy_x_q <= X_START;
        end else begin
            state_q   <= state_d;
            enemy_x_q <= enemy_x_d;
        end
    end

    // Shot request: one-clock pulse with the pre-move x, then a tick-based cooldown.
    always_ff @(posedge clk) begin
        if (reset) begin
            fire_pulse_q <= 1'b0;
            bullet_x_q   <= 8'd0;
            cooldown_q   <= 3'd0;
        end else begin
            fire_pulse_q <= 1'b0;
            if (tick) begin
                if (bus.fire && (cooldown_q == 3'd0) && alive) begin
                    fire_pulse_q <= 1'b1;
                    bullet_x_q   <= user_x_q + BULLET_OFS;
                    cooldown_q   <= FIRE_COOLDOWN;
                end else if (cooldown_q != 3'd0) begin
                    cooldown_q <= cooldown_q - 3'd1;
                end
            end
        end
    end

    // Health and hit immunity: a counted hit reloads immunity and wins over the tick decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            health_q  <= MAX_HEALTH;
            inv_cnt_q <= 5'd0;
        end else begin
            if (bus.hit && alive && (inv_cnt_q == 5'd0)) begin
                health_q  <= health_q - 4'd1;
                inv_cnt_q <= INVULN_TICKS;
            end else if (tick && (inv_cnt_q != 5'd0)) begin
                inv_cnt_q <= inv_cnt_q - 5'd1;
            end
        end
    end

    assign bus.user_x      = user_x_q;
    assign bus.enemy_x     = enemy_x_q;
    assign bus.ship_health = health_q;
    assign bus.fire_pulse  = fire_pulse_q;
    assign bus.bullet_x    = bullet_x_q;
    assign bus.invuln      = (inv_cnt_q != 5'd0);

endmodule
